// File: rtl/md5_pad.sv
// md5_pad: single-block MD5 message padder feeding md5core (m_in/valid_in).
// Takes a raw message one byte per cycle and builds the 512-bit block.
// The block holds the message bytes, then 0x80, then zero fill, then the
// 64-bit little-endian bit length. The block is presented for one enabled
// cycle. Messages of 1..55 bytes are padded. Longer ones are dropped with
// an err strobe.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   synchronous active-low reset (priority over en)
//   en          in   global enable; 0 freezes every register
//   byte_in     in   message byte
//   byte_valid  in   byte_in valid this cycle
//   byte_last   in   this byte ends the message
//   byte_ready  out  byte accepted this cycle (low only while padding)
//   m_out       out  padded block, byte k at m_out[511-8k -: 8]
//   valid_out   out  one-cycle strobe, m_out valid
//   err         out  one-cycle strobe, message longer than 55 bytes dropped
module md5_pad (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic [511:0] m_out,
    output logic         valid_out,
    output logic         err
);

    // Single-block limit of 55 bytes; fixed.
    localparam logic [5:0] MAX_BYTES = 6'd55;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PAD     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [511:0]   buf_r;
    logic [5:0]     cnt_r;
    logic [5:0]     len_r;

    logic           accept_s;
    logic           wr_byte_s;
    logic           clr_s;
    logic           latch_len_s;
    logic           strobe_s;
    logic           err_set_s;
    logic [8:0]     wr_pos_s;
    logic [8:0]     pad_pos_s;
    logic [8:0]     bit_len_s;
    logic [511:0]   pad_block_s;

    // Ready depends on the state only, so a stalled source just holds its byte.
    assign byte_ready = (state_r != ST_PAD);
    assign accept_s   = en & byte_valid & byte_ready;

    // Top bit index of the byte slot at position cnt / L.
    assign wr_pos_s   = 9'd511 - {cnt_r, 3'b000};
    assign pad_pos_s  = 9'd511 - {len_r, 3'b000};
    // 8L is at most 440, so 9 bits hold the whole length.
    assign bit_len_s  = {len_r, 3'b000};

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        wr_byte_s   = 1'b0;
        clr_s       = 1'b0;
        latch_len_s = 1'b0;
        strobe_s    = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s) begin
                    if (cnt_r == MAX_BYTES) begin
                        // 56th byte: overflow. The buffer is cleared right away
                        // so it stays zero while the rest is thrown away.
                        clr_s = 1'b1;
                        if (byte_last) begin
                            err_set_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_DISCARD;
                        end
                    end else begin
                        wr_byte_s = 1'b1;
                        if (byte_last) begin
                            latch_len_s = 1'b1;
                            state_nxt_s = ST_PAD;
                        end else begin
                            state_nxt_s = ST_COLLECT;
                        end
                    end
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_PAD: begin
                strobe_s    = 1'b1;
                clr_s       = 1'b1;
                state_nxt_s = ST_COLLECT;
            end
            ST_DISCARD: begin
                if (accept_s && byte_last) begin
                    err_set_s   = 1'b1;
                    clr_s       = 1'b1;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                clr_s       = 1'b1;
                state_nxt_s = ST_COLLECT;
            end
        endcase
    end

    // Padded block: message, 0x80 marker at byte L, then the little-endian length in bytes 56..63.
    always_comb begin
        pad_block_s                  = buf_r;
        pad_block_s[pad_pos_s -: 8]  = 8'h80;
        pad_block_s[63:0]            = {bit_len_s[7:0], 7'd0, bit_len_s[8], 48'd0};
    end

    // State, buffer and output registers; en low freezes everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_COLLECT;
            buf_r     <= 512'd0;
            cnt_r     <= 6'd0;
            len_r     <= 6'd0;
            m_out     <= 512'd0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else if (en) begin
            state_r   <= state_nxt_s;
            valid_out <= strobe_s;
            err       <= err_set_s;
            m_out     <= strobe_s ? pad_block_s : 512'd0;
            if (clr_s) begin
                buf_r <= 512'd0;
                cnt_r <= 6'd0;
            end else if (wr_byte_s) begin
                buf_r[wr_pos_s -: 8] <= byte_in;
                cnt_r                <= cnt_r + 6'd1;
            end else begin
                buf_r <= buf_r;
                cnt_r <= cnt_r;
            end
            if (latch_len_s) begin
                len_r <= cnt_r + 6'd1;
            end else begin
                len_r <= len_r;
            end
        end else begin
            state_r   <= state_r;
            buf_r     <= buf_r;
            cnt_r     <= cnt_r;
            len_r     <= len_r;
            m_out     <= m_out;
            valid_out <= valid_out;
            err       <= err;
        end
    end

endmodule

// File: tb/tb_md5_pad.sv
// tb_md5_pad: randomized and directed self-checking bench for md5_pad.
// The expected blocks are built from the padding rules with byte arrays
// and arithmetic. A negedge monitor matches every strobe against a
// scoreboard queue. The queue records the kind of each strobe, its cycle
// and its block.
module tb_md5_pad;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [511:0] m_out;
    logic         valid_out;
    logic         err;

    md5_pad dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .m_out      (m_out),
        .valid_out  (valid_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic         is_err;
        logic [511:0] blk;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   msg_q[$];
    logic [511:0] got_hist[$];

    // Reference padding of msg_q (length 1..55).
    function automatic logic [511:0] pad_model();
        logic [7:0]   b [64];
        logic [63:0]  bits;
        logic [63:0]  tmp;
        logic [511:0] r;
        int           len;
        len = msg_q.size();
        for (int k = 0; k < 64; k++) b[k] = 8'h00;
        for (int k = 0; k < len; k++) b[k] = msg_q[k];
        b[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) begin
            tmp = bits >> (8 * i);
            b[56 + i] = tmp[7:0];
        end
        r = 512'd0;
        for (int k = 0; k < 64; k++) r[511 - 8 * k -: 8] = b[k];
        return r;
    endfunction

    // Strobe monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            check_eq("valid_err_excl", 512'(valid_out & err), 512'd0);
            if (!valid_out) check_eq("idle_zero", m_out, 512'd0);
            if (en && (valid_out || err)) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", 512'({valid_out, err}), 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("strobe_kind", 512'({valid_out, err}), 512'(e.is_err ? 2'b01 : 2'b10));
                    check_eq("strobe_cycle", 512'(cyc), 512'(e.cyc));
                    if (valid_out) begin
                        check_eq("block", m_out, e.blk);
                        got_hist.push_back(m_out);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic last, output int acc_cyc);
        int guard;
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        guard      = 0;
        while (!(byte_ready && en)) begin
            tick();
            guard++;
            if (guard > 100) begin
                check_eq("ready_timeout", 512'(byte_ready), 512'd1);
                break;
            end
        end
        tick();
        acc_cyc    = cyc;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_msg(input int unsigned gap_max, input int en_hold);
        int   acc;
        exp_t e;
        acc = 0;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (i > 0) repeat ($urandom_range(gap_max, 0)) tick();
            put_byte(msg_q[i], (i == msg_q.size() - 1), acc);
        end
        e.is_err = (msg_q.size() > 55);
        e.blk    = e.is_err ? 512'd0 : pad_model();
        e.cyc    = e.is_err ? acc : acc + 1 + en_hold;
        exp_q.push_back(e);
        if (en_hold > 0) begin
            en = 1'b0;
            repeat (en_hold) tick();
            en = 1'b1;
        end
    endtask

    task automatic send_partial_then_reset(input int n);
        int acc;
        for (int i = 0; i < n; i++) put_byte(8'($urandom), 1'b0, acc);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("post_reset_ready", 512'(byte_ready), 512'd1);
    endtask

    task automatic load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_fill(input int n, input logic [7:0] v, input logic rnd);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(rnd ? 8'($urandom) : v);
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic check_last(input string tag, input int hi, input int lo, input logic [511:0] exp);
        logic [511:0] blk;
        logic [511:0] fld;
        blk = (got_hist.size() > 0) ? got_hist[got_hist.size() - 1] : 512'd0;
        fld = (blk >> lo) & ((512'd1 << (hi - lo + 1)) - 512'd1);
        check_eq(tag, fld, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] fox_blk;
        reset_n    = 1'b0;
        en         = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check_eq("reset_ready", 512'(byte_ready), 512'd1);
        check_eq("reset_valid", 512'(valid_out), 512'd0);
        check_eq("reset_err", 512'(err), 512'd0);
        check_eq("reset_m_out", m_out, 512'd0);

        load_str("Hello World");
        send_msg(0, 0);
        drain();
        check_last("hello_msg", 511, 416, 512'(96'h48656c6c6f20576f726c6480));
        check_last("hello_fill", 415, 64, 512'd0);
        check_last("hello_len", 63, 0, 512'(64'h5800000000000000));

        load_str("The quick brown fox jumps over the lazy dog");
        send_msg(0, 0);
        load_str("Hello World");
        send_msg(0, 0);
        drain();
        fox_blk = (got_hist.size() >= 2) ? got_hist[got_hist.size() - 2] : 512'd0;
        check_eq("fox_head", 512'(fox_blk[511:480]), 512'(32'h54686520));
        check_eq("fox_tail", 512'(fox_blk[191:0]), 512'(192'h646f678000000000000000000000000058010000_00000000));
        check_last("b2b_hello_len", 63, 0, 512'(64'h5800000000000000));

        load_fill(55, 8'h61, 1'b0);
        send_msg(0, 0);
        drain();
        check_last("max_marker", 71, 64, 512'(8'h80));
        check_last("max_len", 63, 0, 512'(64'hB801000000000000));

        load_fill(1, 8'h00, 1'b0);
        send_msg(0, 0);
        drain();
        check_last("one_head", 511, 496, 512'(16'h0080));
        check_last("one_len", 63, 56, 512'(8'h08));

        load_fill(60, 8'h00, 1'b1);
        send_msg(1, 0);
        load_str("abc");
        send_msg(0, 0);
        drain();
        check_last("abc_head", 511, 480, 512'(32'h61626380));
        check_last("abc_len", 63, 56, 512'(8'h18));

        send_partial_then_reset(20);
        load_str("abc");
        send_msg(0, 0);
        drain();
        check_last("rst_abc_head", 511, 480, 512'(32'h61626380));

        send_partial_then_reset(58);
        load_str("abc");
        send_msg(0, 0);
        drain();
        check_last("rst_disc_abc_len", 63, 56, 512'(8'h18));

        load_str("abc");
        send_msg(0, 5);
        drain();
        check_last("en_hold_head", 511, 480, 512'(32'h61626380));

        for (int m = 0; m < 40; m++) begin
            load_fill(int'($urandom_range(70, 1)), 8'h00, 1'b1);
            send_msg(2, 0);
            repeat ($urandom_range(2, 0)) tick();
        end
        drain();
        check_eq("pending_strobes", 512'(exp_q.size()), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
